// File: rtl/variable_delay_ring_buffer.sv
// rtl/variable_delay_ring_buffer.sv - multi-channel sample-strobed variable delay line on a circular RAM
// Optional feature macro: VARIABLE_DELAY_ZERO_FILL_EN (outputs 0 until the requested sample exists)
module variable_delay_ring_buffer #(
  parameter int DATA_BITS  = 32,
  parameter int DELAY_BITS = 4,
  parameter int CHANNELS   = 2
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic                             CE,
  input  logic                             IN_VALID,
  input  logic [CHANNELS*DATA_BITS-1:0]    IN_VALUE,
  input  logic [CHANNELS*DELAY_BITS-1:0]   DELAY,
  output logic                             OUT_VALID,
  output logic [CHANNELS*DATA_BITS-1:0]    OUT_VALUE
);

  localparam int MEM_SIZE = 1 << DELAY_BITS;
  localparam int WORD     = CHANNELS * DATA_BITS;

  // One word holds a full sample set; never reset so it maps onto RAM.
  logic [WORD-1:0] mem [MEM_SIZE];

  logic [DELAY_BITS-1:0]          wr_ptr;

  logic                           s1_valid;
  logic [WORD-1:0]                s1_value;
  logic [CHANNELS*DELAY_BITS-1:0] s1_delay;
  logic [DELAY_BITS-1:0]          s1_ptr;

  logic                           s2_valid;
  logic [WORD-1:0]                s2_value;
  logic [WORD-1:0]                s2_next;
  logic [WORD-1:0]                out_next;
  logic [DELAY_BITS-1:0]          rd_addr [CHANNELS];

`ifdef VARIABLE_DELAY_ZERO_FILL_EN
  localparam logic [DELAY_BITS:0] FILL_MAX = (DELAY_BITS+1)'(MEM_SIZE);

  logic [DELAY_BITS:0]            fill;
  logic [DELAY_BITS:0]            s1_fill;
  logic [CHANNELS-1:0]            s2_zero;
  logic [CHANNELS-1:0]            s2_zero_next;

  // Count accepted samples (saturating) so requests older than reset can be masked.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fill    <= '0;
      s1_fill <= '0;
    end else if (CE && IN_VALID) begin
      s1_fill <= fill;
      if (fill != FILL_MAX) fill <= fill + (DELAY_BITS+1)'(1);
    end
  end
`endif

  // S1: capture the sample set, its delays and the slot it will occupy; advance the pointer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_delay <= '0;
      s1_ptr   <= '0;
    end else if (CE) begin
      s1_valid <= IN_VALID;
      if (IN_VALID) begin
        s1_value <= IN_VALUE;
        s1_delay <= DELAY;
        s1_ptr   <= wr_ptr;
        wr_ptr   <= wr_ptr + DELAY_BITS'(1);
      end
    end
  end

  // Per-channel read address and zero-delay bypass (the slot being written holds stale data).
  always_comb begin
    s2_next = '0;
`ifdef VARIABLE_DELAY_ZERO_FILL_EN
    s2_zero_next = '0;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      rd_addr[c] = s1_ptr - s1_delay[c*DELAY_BITS +: DELAY_BITS];
      if (s1_delay[c*DELAY_BITS +: DELAY_BITS] == '0)
        s2_next[c*DATA_BITS +: DATA_BITS] = s1_value[c*DATA_BITS +: DATA_BITS];
      else
        s2_next[c*DATA_BITS +: DATA_BITS] = mem[rd_addr[c]][c*DATA_BITS +: DATA_BITS];
`ifdef VARIABLE_DELAY_ZERO_FILL_EN
      s2_zero_next[c] = s1_fill < {1'b0, s1_delay[c*DELAY_BITS +: DELAY_BITS]};
`endif
    end
  end

  // S2 storage write: the sample lands in its slot after the reads above have sampled the RAM.
  always_ff @(posedge CLK) begin
    if (CE && s1_valid) mem[s1_ptr] <= s1_value;
  end

  // S2: register the read or bypassed data for each channel.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_valid <= 1'b0;
      s2_value <= '0;
`ifdef VARIABLE_DELAY_ZERO_FILL_EN
      s2_zero  <= '0;
`endif
    end else if (CE) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_value <= s2_next;
`ifdef VARIABLE_DELAY_ZERO_FILL_EN
        s2_zero  <= s2_zero_next;
`endif
      end
    end
  end

  // Apply the pre-prime mask (when built in) ahead of the output register.
  always_comb begin
    out_next = s2_value;
`ifdef VARIABLE_DELAY_ZERO_FILL_EN
    for (int c = 0; c < CHANNELS; c++) begin
      if (s2_zero[c]) out_next[c*DATA_BITS +: DATA_BITS] = '0;
    end
`endif
  end

  // S3: output register; the value only moves on a valid strobe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OUT_VALID <= 1'b0;
      OUT_VALUE <= '0;
    end else if (CE) begin
      OUT_VALID <= s2_valid;
      if (s2_valid) OUT_VALUE <= out_next;
    end
  end

endmodule

// File: tb/tb_variable_delay_ring_buffer.sv
// tb/tb_variable_delay_ring_buffer.sv - directed self-checking bench for variable_delay_ring_buffer
module tb_variable_delay_ring_buffer;

  logic        CLK;
  logic        RESET_N;
  logic        CE;
  logic        IN_VALID;
  logic [63:0] IN_VALUE;
  logic [7:0]  DELAY;
  logic        OUT_VALID;
  logic [63:0] OUT_VALUE;

  int total;
  int passed;
  int fails;

  // Accepted sample history since the last reset, ch0 in [31:0], ch1 in [63:32].
  logic [63:0] hist [$];

  // Expected-value pipeline: p1/p2 in flight, o_* what the output register should show.
  bit          p1_v, p2_v, o_v;
  logic [63:0] p1_d, p2_d, o_d;
  bit   [1:0]  p1_k, p2_k, o_k;

  variable_delay_ring_buffer #(
    .DATA_BITS (32),
    .DELAY_BITS(4),
    .CHANNELS  (2)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .CE       (CE),
    .IN_VALID (IN_VALID),
    .IN_VALUE (IN_VALUE),
    .DELAY    (DELAY),
    .OUT_VALID(OUT_VALID),
    .OUT_VALUE(OUT_VALUE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output for the sample currently on the inputs, then record it in history.
  task automatic predict(output logic [63:0] d, output bit [1:0] kn);
    int k;
    int dd;
    k  = hist.size();
    d  = '0;
    kn = '0;
    for (int c = 0; c < 2; c++) begin
      dd = int'(DELAY[c*4 +: 4]);
      if (dd == 0) begin
        d[c*32 +: 32] = IN_VALUE[c*32 +: 32];
        kn[c] = 1'b1;
      end else if (k >= dd) begin
        d[c*32 +: 32] = hist[k-dd][c*32 +: 32];
        kn[c] = 1'b1;
      end else begin
`ifdef VARIABLE_DELAY_ZERO_FILL_EN
        kn[c] = 1'b1;
`else
        kn[c] = 1'b0;
`endif
      end
    end
    hist.push_back(IN_VALUE);
  endtask

  // One clock: drive inputs, advance the expected pipeline on CE, check after the edge.
  task automatic cyc(input bit ce, input bit iv, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] d0, input logic [3:0] d1, input string tag);
    CE       = ce;
    IN_VALID = iv;
    IN_VALUE = {b, a};
    DELAY    = {d1, d0};
    @(posedge CLK);
    if (ce) begin
      if (p2_v) begin
        o_d = p2_d;
        o_k = p2_k;
      end
      o_v  = p2_v;
      p2_v = p1_v;
      p2_d = p1_d;
      p2_k = p1_k;
      p1_v = iv;
      if (iv) predict(p1_d, p1_k);
    end
    #1;
    chk($sformatf("%s valid", tag), {63'd0, OUT_VALID}, {63'd0, o_v});
    for (int c = 0; c < 2; c++) begin
      if (o_k[c]) chk($sformatf("%s ch%0d", tag, c), {32'd0, OUT_VALUE[c*32 +: 32]}, {32'd0, o_d[c*32 +: 32]});
    end
  endtask

  // Asynchronous reset between edges: outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    RESET_N = 1'b0;
    #1;
    chk($sformatf("%s async valid", tag), {63'd0, OUT_VALID}, 64'd0);
    chk($sformatf("%s async value", tag), OUT_VALUE, 64'd0);
    hist.delete();
    p1_v = 1'b0;
    p2_v = 1'b0;
    o_v  = 1'b0;
    o_d  = '0;
    o_k  = 2'b11;
    CE       = 1'b1;
    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic flush(input string tag);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0, tag);
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    fails    = 0;
    RESET_N  = 1'b1;
    CE       = 1'b0;
    IN_VALID = 1'b0;
    IN_VALUE = '0;
    DELAY    = '0;
    p1_d     = '0;
    p2_d     = '0;
    p1_k     = '0;
    p2_k     = '0;
    #2;
    do_reset("reset");
    chk("reset held valid", {63'd0, OUT_VALID}, 64'd0);
    chk("reset held value", OUT_VALUE, 64'd0);

    // Ramp: ch0 delayed by 3, ch1 bypassed (delay 0).
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 32'(k), 32'(-k), 4'd3, 4'd0, "ramp");
    flush("ramp tail");

    // Pre-prime behaviour with delay 5 on ch0.
    do_reset("zf reset");
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 32'(k+1), 32'(k+1), 4'd5, 4'd0, "zerofill");
    flush("zerofill tail");

    // Maximum delay across several pointer wraps.
    do_reset("wrap reset");
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b1, 32'(k), 32'(-k), 4'd15, 4'd15, "wrap");
    flush("wrap tail");

    // Delay change on ch0 from 2 to 7 at sample 20.
    do_reset("dchg reset");
    for (int k = 0; k < 30; k++) cyc(1'b1, 1'b1, 32'(k), 32'(k+1000), (k < 20) ? 4'd2 : 4'd7, 4'd1, "dchange");
    flush("dchange tail");

    // Sparse valids with clock-enable gaps, delay 1.
    for (int i = 0; i < 36; i++)
      cyc((i % 4) != 2, (i % 3) == 0, 32'(200+i), 32'(300+i), 4'd1, 4'd1, "gaps");
    flush("gaps tail");

    // Asynchronous reset with samples in flight, then delay 4 afterwards.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 32'(50+k), 32'(60+k), 4'd0, 4'd0, "pre-rst");
    #2;
    do_reset("mid reset");
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 32'(100+k), 32'(400+k), 4'd4, 4'd4, "post-rst");
    flush("post-rst tail");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
